// File: rtl/cpu_controller.sv
// cpu_controller: instruction register, decoder and Moore control FSM for the
// lab CPU datapath. A 16-bit instruction is latched while idle. On a start
// strobe the FSM steps the datapath through register read, ALU evaluation and
// write-back. Every control output depends only on the state and the latched
// instruction.
module cpu_controller (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] in,
  input  logic        load,
  input  logic        s,
  output logic        w,
  output logic        illegal,
  output logic [2:0]  readnum,
  output logic [2:0]  writenum,
  output logic        write,
  output logic [1:0]  vsel,
  output logic        loada,
  output logic        loadb,
  output logic        asel,
  output logic        bsel,
  output logic [1:0]  ALUop,
  output logic [1:0]  shift,
  output logic        loadc,
  output logic        loads,
  output logic [15:0] sximm8,
  output logic [15:0] sximm5
);

  localparam logic [2:0] S_WAIT      = 3'd0;
  localparam logic [2:0] S_DECODE    = 3'd1;
  localparam logic [2:0] S_GET_A     = 3'd2;
  localparam logic [2:0] S_GET_B     = 3'd3;
  localparam logic [2:0] S_ALU       = 3'd4;
  localparam logic [2:0] S_WRITE_REG = 3'd5;
  localparam logic [2:0] S_WRITE_IMM = 3'd6;

  logic [2:0]  state_q, state_d;
  logic [15:0] ir_q, ir_d;

  // Instruction fields
  logic [2:0] opcode, rn, rd, rm;
  logic [1:0] op, sh;

  assign opcode = ir_q[15:13];
  assign op     = ir_q[12:11];
  assign rn     = ir_q[10:8];
  assign rd     = ir_q[7:5];
  assign sh     = ir_q[4:3];
  assign rm     = ir_q[2:0];

  assign sximm8 = {{8{ir_q[7]}}, ir_q[7:0]};
  assign sximm5 = {{11{ir_q[4]}}, ir_q[4:0]};

  // Instruction class decode
  logic is_mov_imm, is_mov_reg, is_alu_op, is_cmp, needs_a, is_legal;

  assign is_mov_imm = (opcode == 3'b110) && (op == 2'b10);
  assign is_mov_reg = (opcode == 3'b110) && (op == 2'b00);
  assign is_alu_op  = (opcode == 3'b101);
  assign is_cmp     = is_alu_op && (op == 2'b01);
  // ADD, CMP and AND read Rn into A; MVN only needs B
  assign needs_a    = is_alu_op && (op != 2'b11);
  assign is_legal   = is_mov_imm || is_mov_reg || is_alu_op;

  // IR only accepts a new word while idle, so it is stable across an instruction
  always_comb begin
    ir_d = ir_q;
    if (load && (state_q == S_WAIT)) begin
      ir_d = in;
    end
  end

  // Next-state sequencing
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_WAIT:      if (s) state_d = S_DECODE;
      S_DECODE: begin
        if (!is_legal)       state_d = S_WAIT;
        else if (is_mov_imm) state_d = S_WRITE_IMM;
        else if (needs_a)    state_d = S_GET_A;
        else                 state_d = S_GET_B;
      end
      S_GET_A:     state_d = S_GET_B;
      S_GET_B:     state_d = S_ALU;
      S_ALU:       state_d = is_cmp ? S_WAIT : S_WRITE_REG;
      S_WRITE_REG: state_d = S_WAIT;
      S_WRITE_IMM: state_d = S_WAIT;
      default:     state_d = S_WAIT;
    endcase
  end

  // State and IR registers, cleared asynchronously so no write can complete after reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_WAIT;
      ir_q    <= 16'h0000;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
    end
  end

  // Moore control outputs decoded from state and IR
  always_comb begin
    w        = 1'b0;
    illegal  = 1'b0;
    readnum  = 3'b000;
    writenum = 3'b000;
    write    = 1'b0;
    vsel     = 2'b00;
    loada    = 1'b0;
    loadb    = 1'b0;
    asel     = 1'b0;
    bsel     = 1'b0;
    ALUop    = 2'b00;
    shift    = 2'b00;
    loadc    = 1'b0;
    loads    = 1'b0;
    case (state_q)
      S_WAIT:   w = 1'b1;
      S_DECODE: illegal = !is_legal;
      S_GET_A: begin
        readnum = rn;
        loada   = 1'b1;
      end
      S_GET_B: begin
        readnum = rm;
        loadb   = 1'b1;
      end
      S_ALU: begin
        shift = sh;
        bsel  = 1'b0;
        // MOV reg passes B through the adder with A forced to zero
        if (is_mov_reg) begin
          asel  = 1'b1;
          ALUop = 2'b00;
        end else begin
          asel  = 1'b0;
          ALUop = op;
        end
        if (is_cmp) loads = 1'b1;
        else        loadc = 1'b1;
      end
      S_WRITE_REG: begin
        writenum = rd;
        vsel     = 2'b11;
        write    = 1'b1;
      end
      S_WRITE_IMM: begin
        writenum = rn;
        vsel     = 2'b01;
        write    = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_cpu_controller.sv
// tb_cpu_controller: drives directed and randomized instructions through
// cpu_controller and compares every cycle's control outputs with a per-instruction
// cycle list built from the instruction semantics.
module tb_cpu_controller;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] in;
  logic        load, s;
  logic        w, illegal, write, loada, loadb, asel, bsel, loadc, loads;
  logic [2:0]  readnum, writenum;
  logic [1:0]  vsel, ALUop, shift;
  logic [15:0] sximm8, sximm5;

  always #5 clk = ~clk;

  cpu_controller dut (
    .clk(clk), .rst_n(rst_n), .in(in), .load(load), .s(s),
    .w(w), .illegal(illegal), .readnum(readnum), .writenum(writenum),
    .write(write), .vsel(vsel), .loada(loada), .loadb(loadb),
    .asel(asel), .bsel(bsel), .ALUop(ALUop), .shift(shift),
    .loadc(loadc), .loads(loads), .sximm8(sximm8), .sximm5(sximm5)
  );

  typedef struct packed {
    logic       w;
    logic       illegal;
    logic [2:0] readnum;
    logic [2:0] writenum;
    logic       write;
    logic [1:0] vsel;
    logic       loada;
    logic       loadb;
    logic       asel;
    logic       bsel;
    logic [1:0] aluop;
    logic [1:0] shift;
    logic       loadc;
    logic       loads;
  } ctl_t;

  int   n_cmp = 0;
  int   n_bad = 0;
  bit   in_rst = 1'b1;
  ctl_t exp_seq [6];
  int   exp_len;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic ctl_t obs_ctl();
    ctl_t c;
    c.w = w; c.illegal = illegal; c.readnum = readnum; c.writenum = writenum;
    c.write = write; c.vsel = vsel; c.loada = loada; c.loadb = loadb;
    c.asel = asel; c.bsel = bsel; c.aluop = ALUop; c.shift = shift;
    c.loadc = loadc; c.loads = loads;
    return c;
  endfunction

  function automatic logic [15:0] sx8(input logic [15:0] ir);
    return {{8{ir[7]}}, ir[7:0]};
  endfunction

  function automatic logic [15:0] sx5(input logic [15:0] ir);
    return {{11{ir[4]}}, ir[4:0]};
  endfunction

  // Reference: list of control vectors, one per busy cycle, for one instruction
  task automatic build_expected(input logic [15:0] ir);
    logic [2:0] opc, rn, rd, rm;
    logic [1:0] op, sh;
    bit movi, movr, alu, cmp, legal, need_a;
    ctl_t c;
    opc = ir[15:13]; op = ir[12:11]; rn = ir[10:8];
    rd = ir[7:5]; sh = ir[4:3]; rm = ir[2:0];
    movi   = (opc == 3'd6) && (op == 2'd2);
    movr   = (opc == 3'd6) && (op == 2'd0);
    alu    = (opc == 3'd5);
    cmp    = alu && (op == 2'd1);
    legal  = movi || movr || alu;
    need_a = alu && (op == 2'd0 || op == 2'd1 || op == 2'd2);
    for (int k = 0; k < 6; k++) exp_seq[k] = '0;
    c = '0; c.illegal = !legal;
    exp_seq[0] = c; exp_len = 1;
    if (!legal) return;
    if (movi) begin
      c = '0; c.writenum = rn; c.vsel = 2'b01; c.write = 1'b1;
      exp_seq[1] = c; exp_len = 2;
      return;
    end
    if (need_a) begin
      c = '0; c.readnum = rn; c.loada = 1'b1;
      exp_seq[exp_len] = c; exp_len++;
    end
    c = '0; c.readnum = rm; c.loadb = 1'b1;
    exp_seq[exp_len] = c; exp_len++;
    c = '0; c.shift = sh; c.asel = movr; c.aluop = movr ? 2'b00 : op;
    if (cmp) c.loads = 1'b1; else c.loadc = 1'b1;
    exp_seq[exp_len] = c; exp_len++;
    if (!cmp) begin
      c = '0; c.writenum = rd; c.vsel = 2'b11; c.write = 1'b1;
      exp_seq[exp_len] = c; exp_len++;
    end
  endtask

  // noise_at: -2 none, -1 random stray loads, k = load 16'hFFFF in busy cycle k
  // rst_at: busy cycle index at which reset is pulled asynchronously (-1 none)
  task automatic run_instr(input logic [15:0] word, input bit hold_s, input bit sep,
                           input int noise_at, input int rst_at);
    ctl_t idle, got;
    idle = '0; idle.w = 1'b1;
    build_expected(word);
    @(negedge clk);
    load = 1'b0;
    check_eq("idle_ctl", 32'(obs_ctl()), 32'(idle));
    if (sep && !in_rst) begin
      in = word; load = 1'b1; s = 1'b0;
      @(negedge clk);
      load = 1'b0;
      check_eq("sep_load_sx8", 32'(sximm8), 32'(sx8(word)));
      check_eq("sep_idle_ctl", 32'(obs_ctl()), 32'(idle));
    end
    in = word; load = 1'b1; s = 1'b1;
    if (in_rst) begin
      rst_n = 1'b1;
      in_rst = 1'b0;
    end
    for (int i = 0; i < exp_len; i++) begin
      @(negedge clk);
      load = 1'b0;
      if (!hold_s) s = 1'b0;
      if (rst_at == i) begin
        #1 rst_n = 1'b0;
        #1;
        check_eq("rst_ctl", 32'(obs_ctl()), 32'(idle));
        check_eq("rst_sx8", 32'(sximm8), 32'h0);
        check_eq("rst_sx5", 32'(sximm5), 32'h0);
        s = 1'b0;
        for (int k = 0; k < 2; k++) begin
          @(negedge clk);
          check_eq("rst_hold_ctl", 32'(obs_ctl()), 32'(idle));
        end
        in_rst = 1'b1;
        $display("instr %h reset at cycle %0d", word, i);
        return;
      end
      got = obs_ctl();
      check_eq($sformatf("ctl_%h_c%0d", word, i), 32'(got), 32'(exp_seq[i]));
      check_eq("sx8", 32'(sximm8), 32'(sx8(word)));
      check_eq("sx5", 32'(sximm5), 32'(sx5(word)));
      if (noise_at == i) begin
        in = 16'hFFFF; load = 1'b1;
      end else if (noise_at == -1 && $urandom_range(3) == 0) begin
        in = 16'($urandom); load = 1'b1;
      end
    end
    $display("instr %h busy %0d cycles hold_s=%0d sep=%0d", word, exp_len, hold_s, sep);
  endtask

  function automatic logic [15:0] rand_word();
    logic [15:0] r;
    r = 16'($urandom);
    case ($urandom_range(3))
      0:       r[15:13] = 3'b110;
      1, 2:    r[15:13] = 3'b101;
      default: ;
    endcase
    return r;
  endfunction

  initial begin
    ctl_t idle;
    idle = '0; idle.w = 1'b1;
    rst_n = 1'b0; in = 16'h0; load = 1'b0; s = 1'b0;
    #12;
    check_eq("por_ctl", 32'(obs_ctl()), 32'(idle));
    check_eq("por_sx8", 32'(sximm8), 32'h0);
    check_eq("por_sx5", 32'(sximm5), 32'h0);

    // Directed cases; the first releases reset on the same edge that samples s
    run_instr(16'hD007, 1'b0, 1'b0, -2, -1);
    run_instr(16'hA148, 1'b0, 1'b0, -2, -1);
    run_instr(16'hA900, 1'b0, 1'b0, -2, -1);
    run_instr(16'hC061, 1'b0, 1'b1, -2, -1);
    run_instr(16'hE000, 1'b0, 1'b0, -2, -1);
    run_instr(16'hA148, 1'b0, 1'b0, 2, -1);
    run_instr(16'hA148, 1'b0, 1'b0, -2, 3);
    run_instr(16'hD0F9, 1'b0, 1'b0, -2, -1);
    run_instr(16'hC061, 1'b1, 1'b0, -2, -1);
    run_instr(16'hA900, 1'b1, 1'b0, -2, -1);
    run_instr(16'hB8E2, 1'b1, 1'b0, -2, -1);

    for (int n = 0; n < 300; n++) begin
      int ra;
      ra = ($urandom_range(24) == 0) ? int'($urandom_range(4)) : -1;
      run_instr(rand_word(), bit'($urandom_range(1)), bit'($urandom_range(1)), -1, ra);
    end

    s = 1'b0; load = 1'b0;
    @(negedge clk);
    if (in_rst) rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check_eq("final_idle", 32'(obs_ctl()), 32'(idle));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/cpu_controller.md
Name: cpu_controller

Overview:
Instruction register, decoder and control FSM that drives the datapath control inputs for the lab CPU. It latches a 16-bit instruction and decodes its fields. A Moore FSM then sequences the datapath: register reads into A/B, ALU evaluation, status load and register-file write-back. A start/wait handshake tells the surrounding test harness when the controller is ready for the next instruction.

Parameters:
none (instruction width is fixed at 16 bits)

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
in  input  16  instruction word
load  input  1  IR load strobe, honoured only when w=1
s  input  1  start strobe, honoured only when w=1
w  output  1  1 = idle/ready (state WAIT)
illegal  output  1  one-cycle pulse when an unsupported instruction is decoded
readnum  output  3  register-file read address
writenum  output  3  register-file write address
write  output  1  register-file write enable
vsel  output  2  write-back select: 00 mdata, 01 sximm8, 10 PC, 11 C
loada  output  1  load register A
loadb  output  1  load register B
asel  output  1  1 = ALU A-input forced to 0
bsel  output  1  1 = ALU B-input is sximm5
ALUop  output  2  00 add, 01 sub, 10 and, 11 not-B
shift  output  2  shifter control
loadc  output  1  load register C
loads  output  1  load status register
sximm8  output  16  IR[7:0] sign-extended
sximm5  output  16  IR[4:0] sign-extended

Behaviour:
- IR fields: opcode=IR[15:13], op=IR[12:11], Rn=IR[10:8], Rd=IR[7:5], sh=IR[4:3], Rm=IR[2:0].
- sximm8 and sximm5 are continuous combinational functions of IR.
- IR update: IR <= in on a clk edge when load=1 and state=WAIT. At all other times load is ignored, so IR is stable for the whole instruction.
- Supported instructions:
  - MOV imm: opcode 110, op 10
  - MOV reg: opcode 110, op 00
  - ADD: opcode 101, op 00
  - CMP: opcode 101, op 01
  - AND: opcode 101, op 10
  - MVN: opcode 101, op 11
  - Anything else is illegal.
- FSM states and transitions:
  - WAIT: w=1. If s=1, go to DECODE.
  - DECODE: MOV imm goes to WRITE_IMM. MOV reg and MVN go to GET_B. ADD, CMP and AND go to GET_A. Illegal: illegal=1 for this cycle, then go to WAIT.
  - GET_A: readnum=Rn, loada=1, go to GET_B.
  - GET_B: readnum=Rm, loadb=1, go to ALU.
  - ALU: shift=sh, bsel=0.
    - MOV reg: asel=1, ALUop=00.
    - Others: asel=0, ALUop=op.
    - CMP: loads=1, loadc=0, go to WAIT.
    - All others: loadc=1, go to WRITE_REG.
  - WRITE_REG: writenum=Rd, vsel=11, write=1, go to WAIT.
  - WRITE_IMM: writenum=Rn, vsel=01, write=1, go to WAIT.
- Outputs are decoded from state and IR only; there is no combinational path from s or load.
- Every control output not listed for a state is 0. readnum, writenum, vsel, ALUop and shift default to 00/000.
- Cycles with w=0, counted from the edge that samples s:
  - MOV imm: 2
  - MOV reg, MVN: 4
  - CMP: 4
  - ADD, AND: 5
- s=1 held continuously: a new instruction starts on the first edge back in WAIT.
- Same-edge load and s in WAIT: IR captures the new word on that edge, and DECODE uses the new IR.
- Reset (async, any state including mid-instruction): state=WAIT, IR=0, w=1. All other outputs 0, sximm8/sximm5=0. No partial write completes after reset is asserted.
- Reset release: the first honoured s is sampled on the first rising edge with rst_n=1.

Test Plan:
- Reset, then load 16'hD007 (MOV R0,#7) and pulse s -> one cycle DECODE, then WRITE_IMM with writenum=0, vsel=01, write=1, sximm8=16'h0007. w returns to 1 on the next edge; w=0 for exactly 2 cycles.
- Load 16'hA148 (ADD R2,R1,R0 LSL#1) with s -> cycle sequence:
  - GET_A: readnum=1, loada=1
  - GET_B: readnum=0, loadb=1
  - ALU: shift=01, ALUop=00, asel=0, loadc=1
  - WRITE_REG: writenum=2, vsel=11, write=1
  - w=0 for 5 cycles.
- Load 16'hA900 (CMP R1,R0) -> ALU state has ALUop=01, loads=1, loadc=0. write is never asserted; FSM returns to WAIT after 4 cycles.
- Load 16'hC061 (MOV R3,R1) -> GET_A is skipped. GET_B has readnum=1. ALU has asel=1, ALUop=00. WRITE_REG has writenum=3.
- Load 16'hE000 -> illegal=1 for exactly the DECODE cycle, no write/load strobes, back in WAIT after 1 cycle.
- Mid-instruction protection: in the GET_B cycle of ADD, drive load=1 with in=16'hFFFF. The IR must not change; the decode-driven outputs in the following states must match an uninterrupted run.
- Mid-instruction reset: in the ALU cycle of ADD, pull rst_n low asynchronously -> all outputs 0 and w=1 immediately; no write strobe occurs afterward.
